// File: rtl/serial_word_serializer_pkg.sv
// Shared definitions for the word serializer: state encoding, width helper
// and the idle line level also used by the downstream detector bench.
package serial_word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_word_serializer_bit_timer.sv
// Per-bit prescaler: counts BIT_CYCLES clocks while enabled and flags the
// final clock of each bit period.
module serializer_bit_timer
    import serial_word_serializer_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic last_cycle
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cyc_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if (restart) begin
            cyc_cnt <= '0;
        end else if (enable) begin
            cyc_cnt <= last_cycle ? '0 : cyc_cnt + 1'b1;
        end
    end

    assign last_cycle = (cyc_cnt == TERMINAL);

endmodule

// File: rtl/serial_word_serializer.sv
// Parallel-to-serial stage feeding the consecutive-zeros detector; accepts a
// word over valid/ready and shifts it out one bit per BIT_CYCLES clocks.
module serial_word_serializer
    import serial_word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter logic        MSB_FIRST  = 1'b1,
    parameter int unsigned BIT_CYCLES = 1,
    parameter logic        IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   BW       = clog2(WIDTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_idx;
    logic             last_cycle;
    logic             last_bit;
    logic             word_end;
    logic             accept;
    logic             cur_bit;

    serializer_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clock      (clock),
        .reset      (reset),
        .enable     (state == SHIFT),
        .restart    (accept),
        .last_cycle (last_cycle)
    );

    assign last_bit   = (bit_idx == LAST_IDX);
    assign word_end   = (state == SHIFT) && last_bit && last_cycle;
    // Ready in the final clock of a word lets the next word follow with no gap.
    assign load_ready = !reset && ((state == IDLE) || word_end);
    assign accept     = load_valid && load_ready;
    assign cur_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (word_end && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bit_out   = IDLE_LEVEL;
        bit_valid = 1'b0;
        busy      = 1'b0;
        if (state == SHIFT) begin
            bit_out   = cur_bit;
            bit_valid = 1'b1;
            busy      = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (accept) begin
            shreg   <= load_data;
            bit_idx <= '0;
        end else if ((state == SHIFT) && last_cycle) begin
            shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= word_end;
        end
    end

endmodule

// File: tb/tb_serial_word_serializer.sv
// Scoreboard bench for serial_word_serializer: two instances (MSB-first with
// 1-clock bits, LSB-first with 3-clock bits) checked against a bit-list model.
module tb_serial_word_serializer;

    localparam int unsigned WIDTH = 8;
    localparam int NI = 2;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] load_data  [NI];
    logic             load_valid [NI];
    logic             load_ready [NI];
    logic             bit_out    [NI];
    logic             bit_valid  [NI];
    logic             busy       [NI];
    logic             done       [NI];

    exp_t             sb        [NI][$];
    logic [WIDTH-1:0] words     [NI][$];
    logic             exp_ready [NI];
    logic             prev_last [NI];
    logic             accepted  [NI];
    int               tests = 0;
    int               fails = 0;

    always #5 clock = ~clock;

    serial_word_serializer #(
        .WIDTH      (WIDTH),
        .MSB_FIRST  (1'b1),
        .BIT_CYCLES (1),
        .IDLE_LEVEL (1'b1)
    ) dut_msb (
        .clock      (clock),
        .reset      (reset),
        .load_data  (load_data[0]),
        .load_valid (load_valid[0]),
        .load_ready (load_ready[0]),
        .bit_out    (bit_out[0]),
        .bit_valid  (bit_valid[0]),
        .busy       (busy[0]),
        .done       (done[0])
    );

    serial_word_serializer #(
        .WIDTH      (WIDTH),
        .MSB_FIRST  (1'b0),
        .BIT_CYCLES (3),
        .IDLE_LEVEL (1'b1)
    ) dut_lsb3 (
        .clock      (clock),
        .reset      (reset),
        .load_data  (load_data[1]),
        .load_valid (load_valid[1]),
        .load_ready (load_ready[1]),
        .bit_out    (bit_out[1]),
        .bit_valid  (bit_valid[1]),
        .busy       (busy[1]),
        .done       (done[1])
    );

    function automatic int unsigned cfg_bc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit cfg_msb(input int k);
        return (k == 0);
    endfunction

    task automatic check(input string name, input int k, input logic actual, input logic expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s inst%0d at %0t: got %b, expected %b", name, k, $time, actual, expected);
        end
    endtask

    // Model: a word becomes WIDTH*BIT_CYCLES line samples in transmit order.
    task automatic push_word(input int k, input logic [WIDTH-1:0] w);
        exp_t        e;
        int unsigned pos;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pos = cfg_msb(k) ? (WIDTH - 1 - i) : i;
            for (int unsigned c = 0; c < cfg_bc(k); c++) begin
                e.b    = w[pos];
                e.last = (i == WIDTH - 1) && (c == cfg_bc(k) - 1);
                sb[k].push_back(e);
            end
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                check("rst_bit_out", k, bit_out[k], 1'b1);
                check("rst_bit_valid", k, bit_valid[k], 1'b0);
                check("rst_busy", k, busy[k], 1'b0);
                check("rst_done", k, done[k], 1'b0);
                check("rst_load_ready", k, load_ready[k], 1'b0);
                sb[k].delete();
                prev_last[k] = 1'b0;
                exp_ready[k] = 1'b0;
            end else begin
                check("done", k, done[k], prev_last[k]);
                if (sb[k].size() > 0) begin
                    e = sb[k].pop_front();
                    check("bit_valid", k, bit_valid[k], 1'b1);
                    check("busy", k, busy[k], 1'b1);
                    check("bit_out", k, bit_out[k], e.b);
                    exp_ready[k] = e.last;
                    prev_last[k] = e.last;
                end else begin
                    check("idle_bit_valid", k, bit_valid[k], 1'b0);
                    check("idle_busy", k, busy[k], 1'b0);
                    check("idle_bit_out", k, bit_out[k], 1'b1);
                    exp_ready[k] = 1'b1;
                    prev_last[k] = 1'b0;
                end
                check("load_ready", k, load_ready[k], exp_ready[k]);
            end
        end
    end

    // Producer: holds each word until the model says it is accepted.
    task automatic step();
        @(negedge clock);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (accepted[k]) begin
                load_valid[k] = 1'b0;
                load_data[k]  = WIDTH'($urandom);
                accepted[k]   = 1'b0;
            end
            if (!load_valid[k] && words[k].size() > 0) begin
                load_data[k]  = words[k].pop_front();
                load_valid[k] = 1'b1;
            end
            if (load_valid[k] && exp_ready[k] && !reset) begin
                push_word(k, load_data[k]);
                accepted[k] = 1'b1;
            end
        end
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = 1'b1;
        for (int k = 0; k < NI; k++) begin
            if (sb[k].size() != 0 || words[k].size() != 0 || load_valid[k] || accepted[k]) idle = 1'b0;
        end
        return idle;
    endfunction

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (n < bound && !all_idle()) begin
            step();
            n++;
        end
        check("drain", -1, all_idle(), 1'b1);
        repeat (3) step();
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            load_valid[k] = 1'b0;
            load_data[k]  = '0;
            accepted[k]   = 1'b0;
            exp_ready[k]  = 1'b0;
            prev_last[k]  = 1'b0;
        end
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) step();

        for (int k = 0; k < NI; k++) words[k].push_back(8'hA5);
        drain(100);
        for (int k = 0; k < NI; k++) words[k].push_back(8'h80);
        drain(100);
        for (int k = 0; k < NI; k++) begin
            words[k].push_back(8'hFF);
            words[k].push_back(8'h00);
        end
        drain(150);
        for (int k = 0; k < NI; k++) words[k].push_back(8'h01);
        drain(100);

        // Abort 8'h0F during its fourth bit on the 1-clock instance.
        for (int k = 0; k < NI; k++) words[k].push_back(8'h0F);
        step();
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        repeat (2) step();
        @(posedge clock);
        #2 reset = 1'b0;
        for (int k = 0; k < NI; k++) words[k].push_back(8'hF0);
        drain(100);

        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NI; k++) begin
                if (words[k].size() == 0 && $urandom_range(0, 3) != 0) begin
                    words[k].push_back(WIDTH'($urandom));
                end
            end
            step();
        end
        drain(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
